// File: rtl/tanh_arbiter.sv
// Round-robin sequencer sharing one variable-latency fp_tanh unit among NUM_REQ
// requesters; an operation that never completes is answered with a quiet-NaN error.
module tanh_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [64*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [63:0]            resp_data,
    output logic                   resp_err,
    output logic                   busy,
    output logic                   tanh_start,
    output logic [63:0]            tanh_in,
    input  logic [63:0]            tanh_out,
    input  logic                   tanh_done
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [63:0]      QNAN      = 64'h7FF8000000000000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [PTR_W-1:0] id_reg, id_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [63:0]      op_reg, op_next;
    logic [63:0]      resp_data_reg, resp_data_next;
    logic             resp_err_reg, resp_err_next;

    logic [PTR_W-1:0] grant;
    logic [PTR_W:0]   scan_idx;
    logic             any_valid;

    // Scan downward from ptr+N-1 to ptr so the last hit is the one closest to ptr.
    always_comb begin
        grant     = '0;
        scan_idx  = '0;
        any_valid = |req_valid;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr_reg} + (PTR_W+1)'(k);
            if (scan_idx >= NUM_REQ_W)
                scan_idx = scan_idx - NUM_REQ_W;
            if (req_valid[scan_idx[PTR_W-1:0]])
                grant = scan_idx[PTR_W-1:0];
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        id_next        = id_reg;
        cnt_next       = cnt_reg;
        op_next        = op_reg;
        resp_data_next = resp_data_reg;
        resp_err_next  = resp_err_reg;
        case (state_reg)
            IDLE: begin
                if (any_valid) begin
                    id_next    = grant;
                    op_next    = req_data[64*grant +: 64];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                // A completion in the final cycle still wins over the timeout.
                if (tanh_done) begin
                    resp_data_next = tanh_out;
                    resp_err_next  = 1'b0;
                    state_next     = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    resp_data_next = QNAN;
                    resp_err_next  = 1'b1;
                    state_next     = RESP;
                end
            end
            RESP: begin
                if (resp_ready[id_reg]) begin
                    ptr_next   = (id_reg == LAST_IDX) ? '0 : id_reg + PTR_W'(1);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            id_reg        <= '0;
            cnt_reg       <= '0;
            op_reg        <= '0;
            resp_data_reg <= '0;
            resp_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            id_reg        <= id_next;
            cnt_reg       <= cnt_next;
            op_reg        <= op_next;
            resp_data_reg <= resp_data_next;
            resp_err_reg  <= resp_err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign req_ready[gi]  = (state_reg == IDLE) && any_valid && (grant == PTR_W'(gi));
            assign resp_valid[gi] = (state_reg == RESP) && (id_reg == PTR_W'(gi));
        end
    endgenerate

    assign resp_data  = resp_data_reg;
    assign resp_err   = resp_err_reg;
    assign busy       = (state_reg != IDLE);
    assign tanh_start = (state_reg == ISSUE);
    assign tanh_in    = op_reg;

endmodule

// File: tb/tb_tanh_arbiter.sv
// Bench for tanh_arbiter: behavioural fp_tanh with programmable latency, scoreboard
// of expected results keyed by accepted requester, directed timing scenarios.
module tb_tanh_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam logic [63:0] QNAN = 64'h7FF8000000000000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [64*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready = '1;
    logic [63:0]    resp_data;
    logic           resp_err;
    logic           busy;
    logic           tanh_start;
    logic [63:0]    tanh_in;
    logic [63:0]    tanh_out = '0;
    logic           tanh_done = 1'b0;

    tanh_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
        .tanh_start(tanh_start), .tanh_in(tanh_in),
        .tanh_out(tanh_out), .tanh_done(tanh_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // fp_tanh stand-in; model_lat == 0 means it never completes
    int          model_lat = 5;
    bit          inject_done = 1'b0;
    logic [63:0] inject_val = '0;
    bit          pending = 1'b0;
    int          remaining = 0;
    logic [63:0] model_res = '0;

    always @(negedge clk) begin
        tanh_done = 1'b0;
        if (!busy) pending = 1'b0;
        if (pending) begin
            remaining--;
            if (remaining == 0) begin
                pending   = 1'b0;
                tanh_done = 1'b1;
                tanh_out  = model_res;
            end
        end
        if (inject_done) begin
            tanh_done = 1'b1;
            tanh_out  = inject_val;
        end
        if (tanh_start && model_lat > 0) begin
            pending   = 1'b1;
            remaining = model_lat;
            model_res = $realtobits($tanh($bitstoreal(tanh_in)));
        end
    end

    typedef struct {
        int          id;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   exp_grants[$];
    bit   expect_timeout = 1'b0;
    int   accept_count = 0;
    int   overlap_viol = 0;
    int   dbl_start = 0;
    bit   start_prev = 1'b0;

    // Monitor: push expectations at accept, pop and compare at response handshake.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            sb.delete();
            start_prev = 1'b0;
        end else begin
            exp_t e;
            int idx;
            logic [63:0] operand;
            if ((|req_ready) && (|resp_valid)) overlap_viol++;
            if (tanh_start && start_prev) dbl_start++;
            start_prev = tanh_start;
            if (|req_ready) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
                operand = req_data[64*idx +: 64];
                e.id   = idx;
                e.data = expect_timeout ? QNAN : $realtobits($tanh($bitstoreal(operand)));
                e.err  = expect_timeout;
                sb.push_back(e);
                accept_count++;
                $display("cyc %0d accept req %0d operand %h", cyc, idx, operand);
                if (exp_grants.size() > 0) chk("grant_order", 64'(idx), 64'(exp_grants.pop_front()));
            end
            if (|(resp_valid & resp_ready)) begin
                $display("cyc %0d resp valid %b data %h err %0b", cyc, resp_valid, resp_data, resp_err);
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 64'(resp_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("resp_id", 64'(resp_valid), 64'(4'(1) << e.id));
                    chk("resp_data", resp_data, e.data);
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                end
            end
        end
    end

    function automatic logic [63:0] rand_bits();
        real r;
        r = ($itor($urandom_range(0, 8000)) / 1000.0) - 4.0;
        return $realtobits(r);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, "_resp_data"}, resp_data, 64'(0));
        chk({tag, "_resp_err"}, 64'(resp_err), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_tanh_start"}, 64'(tanh_start), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_resp(input int idx, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (resp_valid[idx]) return;
        end
        chk(tag, 64'(0), 64'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && !busy) return;
        end
        chk("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    // Present a single requester for one cycle; returns the accept cycle.
    task automatic issue_one(input int idx, input logic [63:0] data, output int t);
        @(negedge clk);
        req_valid = 4'(1) << idx;
        req_data[64*idx +: 64] = data;
        #1;
        chk("accept", 64'(req_ready), 64'(4'(1) << idx));
        t = cyc;
        @(negedge clk);
        req_valid = '0;
        #1;
    endtask

    initial begin
        int t;
        logic [63:0] held;
        real r;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        do_reset();

        // Single op, L=5
        model_lat = 5;
        issue_one(0, 64'hBF747AE147AE147B, t);
        chk("single_start", 64'(tanh_start), 64'(1));
        wait_resp(0, 30, "single_wait");
        chk("single_latency", 64'(cyc - t), 64'(7));
        r = $bitstoreal(resp_data);
        chk("single_value", 64'((r > -0.0049999584) && (r < -0.0049999582)), 64'(1));
        drain();

        // Fairness with operands changing every cycle
        do_reset();
        exp_grants = '{0, 1, 2, 3, 0, 1};
        accept_count = 0;
        model_lat = 3;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (accept_count >= 6) break;
            req_valid = '1;
            for (int j = 0; j < N; j++) req_data[64*j +: 64] = rand_bits();
        end
        req_valid = '0;
        #1;
        chk("fair_accepts", 64'(accept_count), 64'(6));
        drain();
        chk("fair_grants_left", 64'(exp_grants.size()), 64'(0));

        // Backpressure on requester 1; requester 0 waits meanwhile
        resp_ready = 4'b1101;
        issue_one(1, rand_bits(), t);
        wait_resp(1, 30, "bp_wait");
        held = resp_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req_valid = 4'b0001;
            req_data[63:0] = rand_bits();
            #1;
            chk("bp_valid", 64'(resp_valid), 64'(4'b0010));
            chk("bp_data", resp_data, held);
            chk("bp_ready", 64'(req_ready), 64'(0));
            chk("bp_busy", 64'(busy), 64'(1));
        end
        @(negedge clk); resp_ready = '1; #1;
        @(negedge clk); #1;
        chk("bp_idle", 64'(busy), 64'(0));
        chk("bp_next_accept", 64'(req_ready), 64'(4'b0001));
        @(negedge clk); req_valid = '0; #1;
        drain();

        // Timeout, then late and stray done pulses
        model_lat = 0;
        expect_timeout = 1'b1;
        resp_ready = '0;
        issue_one(3, rand_bits(), t);
        wait_resp(3, 40, "to_wait");
        chk("to_latency", 64'(cyc - t), 64'(TO + 2));
        chk("to_data", resp_data, QNAN);
        chk("to_err", 64'(resp_err), 64'(1));
        inject_val = 64'h3FE0000000000000;
        inject_done = 1'b1;
        @(negedge clk); #1;
        inject_done = 1'b0;
        @(negedge clk); #1;
        chk("late_valid", 64'(resp_valid), 64'(4'b1000));
        chk("late_data", resp_data, QNAN);
        @(negedge clk); resp_ready = '1; #1;
        @(negedge clk); #1;
        expect_timeout = 1'b0;
        inject_done = 1'b1;
        @(negedge clk); #1;
        inject_done = 1'b0;
        @(negedge clk); #1;
        chk("stray_busy", 64'(busy), 64'(0));
        chk("stray_data", resp_data, QNAN);

        // Done in the last WAIT cycle
        model_lat = TO;
        issue_one(2, rand_bits(), t);
        wait_resp(2, 40, "sim_wait");
        chk("sim_latency", 64'(cyc - t), 64'(TO + 2));
        chk("sim_err", 64'(resp_err), 64'(0));
        drain();

        // Reset mid-WAIT; ptr must restart at 0
        model_lat = 10;
        issue_one(3, rand_bits(), t);
        repeat (2) @(negedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'(1));
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        req_valid = 4'b1100;
        req_data[128 +: 64] = rand_bits();
        req_data[192 +: 64] = rand_bits();
        #1;
        chk("post_reset_grant", 64'(req_ready), 64'(4'b0100));
        @(negedge clk); req_valid = '0; #1;
        wait_resp(2, 40, "post_reset_wait");
        drain();

        chk("req_resp_overlap", 64'(overlap_viol), 64'(0));
        chk("double_start", 64'(dbl_start), 64'(0));
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tanh_arbiter.md
# tanh_arbiter

Round-robin arbiter and sequencer that shares one `fp_tanh` unit (64-bit IEEE-754 double in/out, start/done handshake, variable latency) among `NUM_REQ` requesters. It sits between the requester ports and the `fp_tanh` instance. It latches one operand at a time, pulses the unit's `start`, and waits for `done`. It then returns the result to the granted requester, and reports an error result if the unit does not finish within `TIMEOUT` cycles.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥ 2.
- `TIMEOUT`, 1023: maximum cycles spent in WAIT before the operation is aborted; must be ≥ 1.
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req_valid` input NUM_REQ: requester i has an operand.
- `req_data` input 64*NUM_REQ: operand of requester i in bits [64i+63:64i], IEEE double.
- `req_ready` output NUM_REQ: accept strobe, one-hot or zero.
- `resp_valid` output NUM_REQ: result valid for requester i, one-hot or zero.
- `resp_ready` input NUM_REQ: requester i takes its result.
- `resp_data` output 64: result, shared by all requesters.
- `resp_err` output 1: result is a timeout error; qualified by `resp_valid`.
- `busy` output 1: FSM is not in IDLE.
- `tanh_start` output 1: one-cycle start pulse to `fp_tanh`.
- `tanh_in` output 64: operand to `fp_tanh`; held stable from `tanh_start` until the operation ends.
- `tanh_out` input 64: `fp_tanh` result; valid in the cycle `tanh_done` is 1.
- `tanh_done` input 1: `fp_tanh` completion pulse.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `grant` = first index with `req_valid` set, searching `ptr`, `ptr`+1, … modulo NUM_REQ (combinational).
  - If any `req_valid` is set: `req_ready[grant]`=1 this cycle (transfer completes this cycle); latch `id`=grant and `op`=`req_data[grant]`; go to ISSUE.
- **ISSUE**
  - `tanh_start`=1 for exactly this cycle; `tanh_in`=`op`.
  - Clear `cnt`; go to WAIT.
- **WAIT**
  - `cnt` increments each cycle.
  - If `tanh_done`: latch `resp_data`=`tanh_out`, `resp_err`=0; go to RESP.
  - Else if `cnt`==TIMEOUT-1: latch `resp_data`=64'h7FF8000000000000 (quiet NaN), `resp_err`=1; go to RESP.
  - `tanh_done` takes priority over timeout in the same cycle.
- **RESP**
  - `resp_valid[id]`=1, with `resp_data` and `resp_err` held, until `resp_ready[id]`=1.
  - `resp_ready` bits of other requesters are ignored.
  - On handshake: `ptr`=(`id`+1) mod NUM_REQ; go to IDLE.
- `tanh_done` outside WAIT (stray or late after a timeout) is ignored; it does not change state or `resp_data`.
- `req_data` is sampled only in the accept cycle; later changes have no effect.
- A requester whose result is pending may re-assert `req_valid`. It is not accepted until the FSM returns to IDLE, and round-robin then favours others.
- `tanh_in` is driven from the `op` register at all times.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - state=IDLE, `ptr`=0, `id`=0, `cnt`=0, `op`=0.
  - Outputs: `resp_data`=0, `resp_err`=0, `req_ready`=0, `resp_valid`=0, `tanh_start`=0, `busy`=0.
- Reset mid-operation abandons the operation with no response. `fp_tanh` shares `rst_n`.
- Accept at cycle T (IDLE) → `tanh_start` at T+1 → `tanh_done` at T+1+L (L ≥ 1) → `resp_valid` at T+2+L.
- Back-to-back: the earliest next accept is the cycle after the response handshake. Minimum period is L+3 cycles with `resp_ready` held high.
- Timeout: with no `tanh_done`, `resp_valid` rises at T+2+TIMEOUT.
- `req_ready` and `resp_valid` never assert in the same cycle.
- `tanh_start` is never high for two consecutive cycles.

## Test plan
- **Single op:** bench `fp_tanh` model with L=5. Requester 0 presents 64'hBF747AE147AE147B (-0.005) at cycle 2.
  - `req_ready[0]` at cycle 2; `tanh_start` at cycle 3; `resp_valid[0]` at cycle 9.
  - `$bitstoreal(resp_data)` = -0.0049999583 within 1e-10; `resp_err`=0.
- **Fairness:** all 4 requesters valid continuously, `resp_ready` all 1.
  - Grants go 0,1,2,3,0,1.
  - Each result returns on the matching `resp_valid` bit with that requester's operand's tanh.
- **Backpressure:** hold `resp_ready[1]`=0 for 20 cycles after `resp_valid[1]`.
  - `resp_valid[1]` and `resp_data` are stable; `req_ready` stays 0; `busy`=1.
  - Release → IDLE next cycle.
- **Timeout:** TIMEOUT=16, model never asserts done.
  - `resp_valid` at T+18 with `resp_data`=64'h7FF8000000000000 and `resp_err`=1.
  - A late `tanh_done` afterwards is ignored.
- **Simultaneous done and timeout:** `tanh_done` in the cycle `cnt`=TIMEOUT-1.
  - Result = `tanh_out`; `resp_err`=0.
- **Reset mid-WAIT:** assert `rst_n`=0 for 1 cycle during WAIT.
  - All outputs return to reset values next cycle; `ptr`=0.
  - A new request from requester 2 completes normally.
